uart_tx_event_queue: RTL and testbench

Buffers game events bound for the PC and serialises them onto the UART transmitter. It sits directly upstream of `uart_tx`. It accepts one-cycle event pulses from the game logic: game over, mole hit, and new mole position. It converts each to its ASCII code ('R', 'H', '0'..'4'), queues the bytes in a small FIFO, and drains them one at a time through the `tx_start`/`tx_busy` handshake, so no event is lost while the transmitter is busy.

---
 rtl/uart_tx_event_queue.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_tx_event_queue.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_event_queue.sv
// uart_tx_event_queue
//   Buffers one-cycle game event pulses (game over, mole hit, new mole
//   position). Each event becomes an ASCII byte ('R', 'H', '0'..'4'), which
//   is queued in a small FIFO. The bytes are handed one at a time to uart_tx
//   through the tx_start / tx_busy handshake.
//
// Ports
//   clock, reset       : system clock; synchronous active-high reset
//   flush              : clears FIFO and pending flags (in-flight byte completes)
//   evt_gameover       : pulse, queues 'R' (0x52)
//   evt_hit            : pulse, queues 'H' (0x48)
//   evt_mole           : pulse, queues '0' + mole_index (index clamped to 4)
//   mole_index [2:0]   : mole number sampled with evt_mole
//   tx_busy            : busy flag from uart_tx
//   tx_start           : one-cycle start pulse to uart_tx
//   tx_data [7:0]      : byte presented to uart_tx
//   fifo_count         : bytes currently queued (0..DEPTH)
//   overflow           : sticky, set when any event is dropped
//   drop_count [7:0]   : dropped events, saturating at 255
module uart_tx_event_queue #(
    parameter int DEPTH        = 8,
    parameter int ADDR_BITS    = 3,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 evt_gameover,
    input  logic                 evt_hit,
    input  logic                 evt_mole,
    input  logic [2:0]           mole_index,
    input  logic                 tx_busy,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic [ADDR_BITS:0]   fifo_count,
    output logic                 overflow,
    output logic [7:0]           drop_count
);

    localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_BUSY = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;

    localparam logic [ADDR_BITS:0]   FULL_CNT = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   CNT_ONE  = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);
    localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);
    localparam logic [TMO_W-1:0]     TMO_ONE  = TMO_W'(1);

    // Saturating add for the drop counter (at most two drops per cycle).
    function automatic logic [7:0] sat_add_drop(input logic [7:0] acc,
                                                input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, acc} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Mole numbers above 4 do not exist on the board; clamp to the last one.
    function automatic logic [2:0] clamp_mole(input logic [2:0] idx);
        return (idx > 3'd4) ? 3'd4 : idx;
    endfunction

    // Pending stage
    logic p_r_q, p_r_d;
    logic p_h_q, p_h_d;
    logic p_m_q, p_m_d;
    logic [2:0] mole_idx_q, mole_idx_d;

    // FIFO
    logic [7:0]           mem_q [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   count_q, count_d;

    // Drain FSM and outputs
    logic [1:0]       state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_q, drop_d;

    logic       fifo_full, fifo_empty, launch;
    logic       wr_en, wr_r, wr_h, wr_m;
    logic [7:0] wr_byte;
    logic       drop_r, drop_h;

    // Fullness uses the count at the start of the cycle, so a pop in the
    // same cycle never makes room for that cycle's write.
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);

    // No new transfer is launched while the FIFO is being flushed.
    assign launch = (state_q == S_IDLE) && !fifo_empty && !tx_busy && !flush;

    assign wr_en   = !flush && !fifo_full && (p_r_q || p_h_q || p_m_q);
    assign wr_r    = wr_en && p_r_q;
    assign wr_h    = wr_en && !p_r_q && p_h_q;
    assign wr_m    = wr_en && !p_r_q && !p_h_q && p_m_q;
    assign wr_byte = p_r_q ? 8'h52 :
                     p_h_q ? 8'h48 :
                             (8'h30 + {5'b00000, mole_idx_q});

    // A repeated R/H event is only lost if its flag stays occupied; a flag
    // that is being written into the FIFO this cycle can take the new event.
    assign drop_r = !flush && evt_gameover && p_r_q && !wr_r;
    assign drop_h = !flush && evt_hit      && p_h_q && !wr_h;

    always_comb begin
        p_r_d      = p_r_q;
        p_h_d      = p_h_q;
        p_m_d      = p_m_q;
        mole_idx_d = mole_idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        tmo_d      = tmo_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        overflow_d = overflow_q | drop_r | drop_h;
        drop_d     = sat_add_drop(drop_q, {1'b0, drop_r} + {1'b0, drop_h});

        if (flush) begin
            p_r_d    = 1'b0;
            p_h_d    = 1'b0;
            p_m_d    = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            p_r_d = (p_r_q && !wr_r) || evt_gameover;
            p_h_d = (p_h_q && !wr_h) || evt_hit;
            p_m_d = (p_m_q && !wr_m) || evt_mole;
            // Latest mole position wins; the byte written this cycle still
            // uses the previously latched index.
            if (evt_mole) begin
                mole_idx_d = clamp_mole(mole_index);
            end
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (launch) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({wr_en, launch})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        // The FSM ignores flush so a byte already handed over completes.
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d    = S_WAIT_BUSY;
                    tmo_d      = '0;
                    tx_start_d = 1'b1;
                    tx_data_d  = mem_q[rd_ptr_q];
                end
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    // Transmitter never acknowledged; treat the byte as sent.
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            p_r_q      <= 1'b0;
            p_h_q      <= 1'b0;
            p_m_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            tmo_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            overflow_q <= 1'b0;
            drop_q     <= 8'h00;
        end else begin
            p_r_q      <= p_r_d;
            p_h_q      <= p_h_d;
            p_m_q      <= p_m_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Data-only storage: contents are meaningless until written.
    always_ff @(posedge clock) begin
        mole_idx_q <= mole_idx_d;
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_byte;
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_uart_tx_event_queue.sv
module tb_uart_tx_event_queue;

    localparam int DEPTH     = 8;
    localparam int ADDR_BITS = 3;
    localparam int BT        = 4;

    logic                clock = 1'b0;
    logic                reset, flush, evt_gameover, evt_hit, evt_mole;
    logic [2:0]          mole_index;
    logic                tx_busy;
    logic                tx_start;
    logic [7:0]          tx_data;
    logic [ADDR_BITS:0]  fifo_count;
    logic                overflow;
    logic [7:0]          drop_count;

    always #5 clock = ~clock;

    uart_tx_event_queue #(
        .DEPTH(DEPTH), .ADDR_BITS(ADDR_BITS), .BUSY_TIMEOUT(BT)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .evt_gameover(evt_gameover), .evt_hit(evt_hit), .evt_mole(evt_mole),
        .mole_index(mole_index), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data), .fifo_count(fifo_count),
        .overflow(overflow), .drop_count(drop_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, want, want, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    int  mq[$];               // queued bytes, head first
    bit  m_pr, m_ph, m_pm;    // events waiting for a FIFO slot
    int  m_midx;
    bit  m_wrise, m_wfall;    // handshake: waiting for busy to rise / fall
    int  m_wcnt;              // cycles spent waiting for busy to rise
    bit  m_start;
    int  m_data, m_drops;
    bit  m_ovf;

    task automatic model_step();
        bit full, idle, go, w_r, w_h, w_m;
        int wbyte, ndrop;
        if (reset) begin
            mq.delete();
            m_pr = 0; m_ph = 0; m_pm = 0;
            m_wrise = 0; m_wfall = 0; m_wcnt = 0;
            m_start = 0; m_data = 0; m_drops = 0; m_ovf = 0;
            return;
        end
        full  = (mq.size() == DEPTH);
        idle  = !m_wrise && !m_wfall;
        go    = idle && (mq.size() != 0) && !tx_busy && !flush;
        w_r = 0; w_h = 0; w_m = 0;
        if (!flush && !full) begin
            if (m_pr) w_r = 1;
            else if (m_ph) w_h = 1;
            else if (m_pm) w_m = 1;
        end
        wbyte = w_r ? 'h52 : (w_h ? 'h48 : 'h30 + m_midx);

        // handshake with the transmitter
        m_start = go;
        if (go) begin
            m_data  = mq.pop_front();
            m_wrise = 1;
            m_wcnt  = 0;
        end else if (m_wrise) begin
            if (tx_busy) begin
                m_wrise = 0;
                m_wfall = 1;
            end else begin
                m_wcnt++;
                if (m_wcnt >= BT) m_wrise = 0;
            end
        end else if (m_wfall && !tx_busy) begin
            m_wfall = 0;
        end

        ndrop = 0;
        if (flush) begin
            mq.delete();
            m_pr = 0; m_ph = 0; m_pm = 0;
        end else begin
            if (w_r || w_h || w_m) mq.push_back(wbyte);
            if (evt_gameover && m_pr && !w_r) ndrop++;
            if (evt_hit && m_ph && !w_h) ndrop++;
            m_pr = (m_pr && !w_r) || evt_gameover;
            m_ph = (m_ph && !w_h) || evt_hit;
            if (evt_mole) begin
                m_midx = (mole_index > 3'd4) ? 4 : int'(mole_index);
                m_pm   = 1;
            end else begin
                m_pm = m_pm && !w_m;
            end
        end
        if (ndrop > 0) begin
            m_ovf   = 1;
            m_drops = (m_drops + ndrop > 255) ? 255 : m_drops + ndrop;
        end
    endtask

    // ---------------- uart_tx stand-in ----------------
    int ub_mode  = 2;   // 0: respond to tx_start, 1: held high, 2: held low
    int cfg_dly  = 1;   // cycles from tx_start to busy rising
    int cfg_hold = 10;  // busy high time (0: never rises)
    int r_dly    = 0;
    int h_left   = 0;

    task automatic busy_gen();
        if (ub_mode == 1) begin
            tx_busy = 1'b1; r_dly = 0; h_left = 0;
        end else if (ub_mode == 2) begin
            tx_busy = 1'b0; r_dly = 0; h_left = 0;
        end else begin
            if (tx_start) r_dly = cfg_dly;
            if (r_dly > 0) begin
                r_dly--;
                if (r_dly == 0) h_left = cfg_hold;
            end
            tx_busy = (h_left > 0);
            if (h_left > 0) h_left--;
        end
    endtask

    int cyc = 0;
    int sent[$];
    int starts[$];

    // One clock: model follows the edge, outputs compared on the falling
    // edge, then one-cycle pulses are released and tx_busy updated.
    task automatic step();
        @(posedge clock);
        model_step();
        cyc++;
        @(negedge clock);
        check_eq("tx_start",   tx_start,   m_start);
        check_eq("tx_data",    tx_data,    m_data);
        check_eq("fifo_count", fifo_count, mq.size());
        check_eq("overflow",   overflow,   m_ovf);
        check_eq("drop_count", drop_count, m_drops);
        if (tx_start) begin
            sent.push_back(tx_data);
            starts.push_back(cyc);
        end
        reset = 0; flush = 0;
        evt_gameover = 0; evt_hit = 0; evt_mole = 0;
        busy_gen();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        reset = 1; flush = 0; evt_gameover = 0; evt_hit = 0; evt_mole = 0;
        mole_index = 0; tx_busy = 0;

        // reset state
        step();
        check_eq("rst_fifo_count", fifo_count, 0);
        check_eq("rst_tx_start",   tx_start,   0);
        check_eq("rst_tx_data",    tx_data,    0);
        check_eq("rst_overflow",   overflow,   0);
        check_eq("rst_drop_count", drop_count, 0);
        run(2);

        // single mole event, start pulse three edges later
        ub_mode = 0; cfg_dly = 1; cfg_hold = 10;
        sent.delete();
        evt_mole = 1; mole_index = 3'd3;
        run(2);
        check_eq("single_early", tx_start, 0);
        step();
        check_eq("single_start", tx_start, 1);
        check_eq("single_data",  tx_data,  'h33);
        run(20);
        check_eq("single_pulses", sent.size(), 1);

        // simultaneous events drain in priority order
        sent.delete();
        evt_gameover = 1; evt_hit = 1; evt_mole = 1; mole_index = 3'd1;
        run(70);
        check_eq("simul_count", sent.size(), 3);
        if (sent.size() == 3) begin
            check_eq("simul_b0", sent[0], 'h52);
            check_eq("simul_b1", sent[1], 'h48);
            check_eq("simul_b2", sent[2], 'h31);
        end
        check_eq("simul_drops", drop_count, 0);

        // backpressure: fill the FIFO, hold one pending, drop one
        ub_mode = 1;
        step();
        for (int i = 0; i < 8; i++) begin
            evt_hit = 1;
            run(3);
        end
        check_eq("bp_full", fifo_count, 8);
        evt_hit = 1;
        run(3);
        evt_hit = 1;
        run(2);
        check_eq("bp_full2",    fifo_count, 8);
        check_eq("bp_overflow", overflow,   1);
        check_eq("bp_drops",    drop_count, 1);
        sent.delete();
        ub_mode = 0; cfg_dly = 1; cfg_hold = 3;
        run(150);
        check_eq("bp_sent", sent.size(), 9);
        foreach (sent[i]) check_eq("bp_byte", sent[i], 'h48);

        // flush with a byte in flight
        cfg_hold = 20;
        for (int i = 0; i < 6; i++) begin
            evt_hit = 1;
            run(3);
        end
        check_eq("fl_pre_count", fifo_count, 5);
        flush = 1; evt_hit = 1;
        step();
        check_eq("fl_count", fifo_count, 0);
        sent.delete();
        run(40);
        check_eq("fl_no_start", sent.size(), 0);
        check_eq("fl_drops",    drop_count, 1);

        // busy never rises: each byte times out and is not retried
        ub_mode = 2;
        step();
        sent.delete(); starts.delete();
        evt_gameover = 1; evt_hit = 1; evt_mole = 1; mole_index = 3'd7;
        run(30);
        check_eq("to_count", sent.size(), 3);
        if (sent.size() == 3) begin
            check_eq("to_b0", sent[0], 'h52);
            check_eq("to_b1", sent[1], 'h48);
            check_eq("to_b2", sent[2], 'h34);
            check_eq("to_gap0", starts[1] - starts[0], BT + 1);
            check_eq("to_gap1", starts[2] - starts[1], BT + 1);
        end

        // reset in the middle of a transfer with bytes queued
        ub_mode = 0; cfg_dly = 1; cfg_hold = 20;
        for (int i = 0; i < 4; i++) begin
            evt_hit = 1;
            run(3);
        end
        check_eq("rm_pre_count", fifo_count, 3);
        reset = 1;
        step();
        check_eq("rm_fifo_count", fifo_count, 0);
        check_eq("rm_tx_start",   tx_start,   0);
        check_eq("rm_tx_data",    tx_data,    0);
        check_eq("rm_overflow",   overflow,   0);
        check_eq("rm_drop_count", drop_count, 0);

        // randomized traffic against the model
        for (int i = 0; i < 5000; i++) begin
            if (i % 250 == 0) begin
                ub_mode  = ($urandom % 4 == 0) ? int'($urandom % 3) : 0;
                cfg_dly  = $urandom_range(1, BT + 1);
                cfg_hold = $urandom_range(0, 8);
            end
            evt_gameover = ($urandom % 5 == 0);
            evt_hit      = ($urandom % 4 == 0);
            evt_mole     = ($urandom % 4 == 0);
            mole_index   = 3'($urandom % 8);
            flush        = ($urandom % 90 == 0);
            reset        = ($urandom % 900 == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
